tmr_lane_manager: RTL

Fault-management controller for a three-lane TMR signal path. It registers the three redundant lanes, votes them, and tracks which lane is the minority and how persistently. A lane that is persistently wrong is masked, and the block drops to two-lane operation. A masked lane is re-admitted after sustained agreement. The block sits directly after the redundant lane sources and drives the voted bit plus health status to the system monitor.

---
 rtl/tmr_lane_manager.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/tmr_lane_manager.sv
// Three-lane TMR vote with per-lane miss tracking, lane masking, re-admission
// after sustained agreement, and a latched fatal state on two-lane disagreement.
module tmr_lane_manager #(
    parameter int unsigned FAULT_THRESH   = 4,
    parameter int unsigned RECOVER_CYCLES = 16,
    parameter int unsigned CNT_W          = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             c_in,
    input  logic             clear,
    output logic             voted_out,
    output logic             error,
    output logic [2:0]       lane_fault,
    output logic             degraded,
    output logic             fatal,
    output logic [CNT_W-1:0] err_count
);

    localparam int unsigned MW = 8;
    localparam logic [MW-1:0]    FAULT_LIM = MW'(FAULT_THRESH);
    localparam logic [MW-1:0]    REC_LIM   = MW'(RECOVER_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {ST_TMR, ST_DEGRADED, ST_FATAL} state_e;

    state_e           state_q, state_d;
    logic [2:0]       lane_q;
    logic             voted_q, voted_d;
    logic             error_q, error_d;
    logic [2:0]       fault_q, fault_d;
    logic             degraded_q, degraded_d;
    logic             fatal_q, fatal_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [MW-1:0]    miss_q [3];
    logic [MW-1:0]    miss_d [3];
    logic [MW-1:0]    rec_q, rec_d;

    logic [2:0]       minority_c;
    logic [2:0]       thresh_hit_c;
    logic             majority_c;
    logic             act_x_c, act_y_c, masked_c;
    logic             pair_eq_c;
    logic             rec_hit_c;

    // Voting terms and the active/masked lane view used while degraded.
    always_comb begin
        minority_c[0] = (lane_q[0] != lane_q[1]) && (lane_q[1] == lane_q[2]);
        minority_c[1] = (lane_q[1] != lane_q[0]) && (lane_q[0] == lane_q[2]);
        minority_c[2] = (lane_q[2] != lane_q[0]) && (lane_q[0] == lane_q[1]);
        majority_c    = (lane_q[0] & lane_q[1]) | (lane_q[1] & lane_q[2]) |
                        (lane_q[0] & lane_q[2]);
        for (int i = 0; i < 3; i++) begin
            thresh_hit_c[i] = minority_c[i] && ((miss_q[i] + MW'(1)) == FAULT_LIM);
        end
        act_x_c  = lane_q[0];
        act_y_c  = lane_q[1];
        masked_c = lane_q[2];
        case (fault_q)
            3'b001: begin act_x_c = lane_q[1]; act_y_c = lane_q[2]; masked_c = lane_q[0]; end
            3'b010: begin act_x_c = lane_q[0]; act_y_c = lane_q[2]; masked_c = lane_q[1]; end
            default: ;
        endcase
        pair_eq_c = (act_x_c == act_y_c);
        rec_hit_c = pair_eq_c && (masked_c == act_x_c) && ((rec_q + MW'(1)) == REC_LIM);
    end

    // State register.
    always_ff @(posedge clock) begin
        if (!reset_n) state_q <= ST_TMR;
        else          state_q <= state_d;
    end

    // Next-state logic; clear wins over threshold and recovery.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_TMR;
        end else begin
            case (state_q)
                ST_TMR:      if (|thresh_hit_c) state_d = ST_DEGRADED;
                ST_DEGRADED: begin
                    if (!pair_eq_c)     state_d = ST_FATAL;
                    else if (rec_hit_c) state_d = ST_TMR;
                end
                ST_FATAL:    state_d = ST_FATAL;
                default:     state_d = ST_TMR;
            endcase
        end
    end

    // Output and counter next values.
    always_comb begin
        voted_d    = voted_q;
        fault_d    = fault_q;
        miss_d     = miss_q;
        rec_d      = rec_q;
        error_d    = |minority_c;
        cnt_d      = cnt_q;
        degraded_d = (state_d == ST_DEGRADED);
        fatal_d    = (state_d == ST_FATAL);
        if (clear) begin
            cnt_d   = '0;
            fault_d = '0;
            rec_d   = '0;
            for (int i = 0; i < 3; i++) miss_d[i] = '0;
        end else begin
            if (error_d && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_W'(1);
            case (state_q)
                ST_TMR: begin
                    voted_d = majority_c;
                    for (int i = 0; i < 3; i++) begin
                        miss_d[i] = minority_c[i] ? (miss_q[i] + MW'(1)) : '0;
                    end
                    if (|thresh_hit_c) begin
                        fault_d = thresh_hit_c;
                        for (int i = 0; i < 3; i++) miss_d[i] = '0;
                    end
                end
                ST_DEGRADED: begin
                    if (pair_eq_c) begin
                        voted_d = act_x_c;
                        rec_d   = (masked_c == act_x_c) ? (rec_q + MW'(1)) : '0;
                        if (rec_hit_c) begin
                            fault_d = '0;
                            rec_d   = '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Lane capture and registered stage-2 outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            lane_q     <= '0;
            voted_q    <= 1'b0;
            error_q    <= 1'b0;
            fault_q    <= '0;
            degraded_q <= 1'b0;
            fatal_q    <= 1'b0;
            cnt_q      <= '0;
            rec_q      <= '0;
            for (int i = 0; i < 3; i++) miss_q[i] <= '0;
        end else begin
            lane_q     <= {c_in, b_in, a_in};
            voted_q    <= voted_d;
            error_q    <= error_d;
            fault_q    <= fault_d;
            degraded_q <= degraded_d;
            fatal_q    <= fatal_d;
            cnt_q      <= cnt_d;
            rec_q      <= rec_d;
            for (int i = 0; i < 3; i++) miss_q[i] <= miss_d[i];
        end
    end

    assign voted_out  = voted_q;
    assign error      = error_q;
    assign lane_fault = fault_q;
    assign degraded   = degraded_q;
    assign fatal      = fatal_q;
    assign err_count  = cnt_q;

endmodule
